// File: rtl/spi_slave_shift_engine_if.sv
// SPI slave shift engine bus bundle: the serial pins plus the parallel
// tx/rx handshake seen by the slave-side producer/consumer logic.
// The slave modport is the engine's view; master is the driver's view.
interface spi_slave_shift_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sclk;
    logic                  cs;
    logic                  mosi0;
    logic                  miso0;
    logic                  cpol;
    logic                  cpha;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  frame_err;

    modport slave (
        input  sclk, cs, mosi0, cpol, cpha, tx_data, tx_valid,
        output miso0, tx_ready, rx_data, rx_valid, busy, frame_err
    );

    modport master (
        output sclk, cs, mosi0, cpol, cpha, tx_data, tx_valid,
        input  miso0, tx_ready, rx_data, rx_valid, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_shift_engine.sv
// SPI slave shift engine: oversamples sclk/cs/mosi0 in the pclk domain,
// assembles LSB-first frames into rx words and shifts tx words out on miso0.
// sclk is synchronised as (sclk ^ cpol) so the synchroniser idles at 0 for
// either polarity and a rising edge of the normalised clock is always the
// leading edge.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_CHECK_EN enables frame_err
// pulses on aborted frames and tx underruns; otherwise frame_err is 0.
module spi_slave_shift_engine #(
    parameter int                    DATA_WIDTH      = 8,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE_PATTERN = '0,
    parameter int                    SYNC_STAGES     = 2
) (
    input logic                     pclk,
    input logic                     areset,
    spi_slave_shift_engine_if.slave bus
);
    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_p0, cs_p0, mosi_p0;
    logic                   sclk_p1, cs_p1;

    logic [0:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  miso_q;

    logic                  lead_edge, trail_edge, sample_edge, shift_edge;
    logic                  active, cs_fall, frame_start, frame_end, run;
    logic                  do_sample, do_shift, word_done, load, tx_write;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] rx_next;

    // Synchronisers; reset to the idle bus (normalised sclk low, cs high).
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_p1   <= 1'b0;
            cs_p1     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk ^ bus.cpol};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi0};
            sclk_p1   <= sclk_p0;
            cs_p1     <= cs_p0;
        end
    end

    assign sclk_p0 = sclk_sync[SYNC_STAGES-1];
    assign cs_p0   = cs_sync[SYNC_STAGES-1];
    assign mosi_p0 = mosi_sync[SYNC_STAGES-1];

    // Edge classification and frame control decode.
    always_comb begin
        lead_edge   = sclk_p0 & ~sclk_p1;
        trail_edge  = ~sclk_p0 & sclk_p1;
        sample_edge = bus.cpha ? trail_edge : lead_edge;
        shift_edge  = bus.cpha ? lead_edge : trail_edge;
        active      = (state == ST_ACTIVE);
        cs_fall     = cs_p1 & ~cs_p0;
        frame_start = !active && cs_fall;
        frame_end   = active && cs_p0;
        run         = active && !cs_p0;
        do_sample   = run && sample_edge;
        do_shift    = run && shift_edge;
        word_done   = do_sample && (bit_cnt == CNT_LAST);
        // A back-to-back word reloads at the last sample of the previous one.
        load        = frame_start || word_done;
        tx_write    = bus.tx_valid && !hold_full;
        load_word   = hold_full ? hold_data : TX_IDLE_PATTERN;
        rx_next     = {mosi_p0, rx_shift};
    end

    // Frame FSM, bit counter, holding-register flag, rx strobe and miso0.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            hold_full  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            miso_q     <= 1'b0;
        end else begin
            if (frame_start) begin
                state <= ST_ACTIVE;
            end else if (frame_end) begin
                state <= ST_IDLE;
            end

            if (!run) begin
                bit_cnt <= '0;
            end else if (do_sample) begin
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end

            // A load with an empty holding reg takes the idle pattern while a
            // same-cycle write is still captured.
            hold_full  <= tx_write || (hold_full && !load);
            rx_valid_q <= word_done;
            if (word_done) begin
                rx_data_q <= rx_next;
            end

            // cpha=0 presents bit 0 straight after cs falls; cpha=1 waits for
            // the first leading edge, which is a shift edge in that mode.
            if (frame_start) begin
                miso_q <= bus.cpha ? 1'b0 : load_word[0];
            end else if (!active || frame_end) begin
                miso_q <= 1'b0;
            end else if (do_shift) begin
                miso_q <= tx_shift[0];
            end
        end
    end

    // Data shift registers and holding register; control alone gates them.
    always_ff @(posedge pclk) begin
        if (tx_write) begin
            hold_data <= bus.tx_data;
        end
        if (frame_start) begin
            tx_shift <= bus.cpha ? load_word : (load_word >> 1);
        end else if (word_done) begin
            tx_shift <= load_word;
        end else if (do_shift) begin
            tx_shift <= tx_shift >> 1;
        end
        if (do_sample) begin
            rx_shift <= rx_next[DATA_WIDTH-1:1];
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_CHECK_EN
    logic err_q;

    // Abort (cs rise mid-word) or underrun (load from an empty holding reg).
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (frame_end && (bit_cnt != '0)) || (load && !hold_full);
        end
    end

    assign bus.frame_err = err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.miso0    = miso_q;
    assign bus.tx_ready = !hold_full;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = active;

endmodule
